// File: rtl/prog_stream_tx.sv
// rtl/prog_stream_tx.sv - bit-serial instruction-load transmitter
// Shifts host words out LSB first in one contiguous enable window per load.
module prog_stream_tx #(
  parameter int INSTR_WIDTH = 13,
  parameter int MAX_WORDS   = 1000,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_words,
  input  logic                   in_valid,
  input  logic [INSTR_WIDTH-1:0] in_word,
  output logic                   in_ready,
  output logic                   ser_en,
  output logic                   ser_data,
  output logic                   busy,
  output logic                   done,
  output logic                   underrun
);

  localparam int BC_W = $clog2(INSTR_WIDTH);
  localparam logic [BC_W-1:0]        BC_LAST = BC_W'(INSTR_WIDTH - 1);
  localparam logic [BC_W-1:0]        BC_ONE  = BC_W'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] MAX_N   = COUNT_WIDTH'(MAX_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_SHIFT, S_FIN} state_t;

  state_t                 state, state_nx;
  logic [INSTR_WIDTH-1:0] sh, sh_nx;
  logic [INSTR_WIDTH-1:0] hold;
  logic                   hold_v, hold_v_nx;
  logic [BC_W-1:0]        bc, bc_nx;
  logic [COUNT_WIDTH-1:0] acc, acc_nx;
  logic [COUNT_WIDTH-1:0] sent, sent_nx;
  logic [COUNT_WIDTH-1:0] n, n_nx;
  logic [COUNT_WIDTH-1:0] n_req;
  logic                   underrun_nx;
  logic                   accept;

  assign n_req  = (num_words > MAX_N) ? MAX_N : num_words;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_FIN);
  // FIN discards the holding register, so words are not taken there.
  assign in_ready = ((state == S_PRIME) || (state == S_SHIFT)) && !hold_v && (acc < n);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nx    = state;
    sh_nx       = sh;
    hold_v_nx   = hold_v;
    bc_nx       = bc;
    acc_nx      = acc;
    sent_nx     = sent;
    n_nx        = n;
    underrun_nx = underrun;
    if (accept) begin
      hold_v_nx = 1'b1;
      acc_nx    = acc + CNT_ONE;
    end
    case (state)
      S_IDLE: begin
        if (start) begin
          n_nx        = n_req;
          underrun_nx = 1'b0;
          acc_nx      = '0;
          sent_nx     = '0;
          hold_v_nx   = 1'b0;
          state_nx    = (n_req == '0) ? S_FIN : S_PRIME;
        end
      end
      S_PRIME: begin
        if (hold_v) begin
          sh_nx     = hold;
          hold_v_nx = 1'b0;
          bc_nx     = '0;
          state_nx  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bc == BC_LAST) begin
          sent_nx = sent + CNT_ONE;
          if (sent + CNT_ONE == n) begin
            state_nx = S_FIN;
          end else if (hold_v) begin
            // Reload on the same edge so the enable window has no gap.
            sh_nx     = hold;
            hold_v_nx = 1'b0;
            bc_nx     = '0;
          end else begin
            underrun_nx = 1'b1;
            state_nx    = S_FIN;
          end
        end else begin
          sh_nx = sh >> 1;
          bc_nx = bc + BC_ONE;
        end
      end
      S_FIN: begin
        hold_v_nx = 1'b0;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      sh       <= '0;
      hold     <= '0;
      hold_v   <= 1'b0;
      bc       <= '0;
      acc      <= '0;
      sent     <= '0;
      n        <= '0;
      underrun <= 1'b0;
      ser_en   <= 1'b0;
      ser_data <= 1'b0;
    end else begin
      state    <= state_nx;
      sh       <= sh_nx;
      hold_v   <= hold_v_nx;
      bc       <= bc_nx;
      acc      <= acc_nx;
      sent     <= sent_nx;
      n        <= n_nx;
      underrun <= underrun_nx;
      if (accept) hold <= in_word;
      ser_en   <= (state_nx == S_SHIFT);
      ser_data <= (state_nx == S_SHIFT) && sh_nx[0];
    end
  end

endmodule

// File: tb/tb_prog_stream_tx.sv
// tb/tb_prog_stream_tx.sv - self-checking bench for prog_stream_tx
// Loads are checked against the expected LSB-first bit stream of the offered words.
module tb_prog_stream_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  num_words = '0;
  logic        in_valid = 1'b0;
  logic [12:0] in_word = '0;
  logic        in_ready, ser_en, ser_data, busy, done, underrun;

  prog_stream_tx dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .ser_en(ser_en), .ser_data(ser_data), .busy(busy), .done(done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [12:0] words_q[$];
  bit          obs_bits[$];
  bit          mon_on = 0;
  bit          prev_en = 0;
  int          hs_count, en_cycles, en_rises, done_count;

  always @(negedge clk) begin
    if (mon_on) begin
      if (in_valid && in_ready) hs_count++;
      if (ser_en) begin
        en_cycles++;
        obs_bits.push_back(ser_data);
        if (!prev_en) en_rises++;
      end
      if (done) done_count++;
    end
    prev_en = ser_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one load of num words, offering words_q[0..offer-1].
  task automatic run_load(input string tag, input int num, input int offer,
                          input int first_delay, input int gap_max, input bit poke);
    int  n_eff, guard, bad;
    bit  rdy;
    bit  exp_bits[$];
    n_eff = (num > 1000) ? 1000 : num;
    exp_bits = {};
    for (int i = 0; i < offer; i++)
      for (int b = 0; b < 13; b++) exp_bits.push_back(words_q[i][b]);
    obs_bits = {};
    hs_count = 0; en_cycles = 0; en_rises = 0; done_count = 0;
    mon_on = 1;
    start = 1'b1;
    num_words = 10'(num);
    tick();
    start = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
    chk({tag, "_underrun_clr"}, underrun, 0);
    chk({tag, "_ready_rise"}, in_ready, (n_eff > 0));
    chk({tag, "_done_zero"}, done, (n_eff == 0));
    for (int i = 0; i < offer; i++) begin
      repeat ((i == 0) ? first_delay : $urandom_range(gap_max, 0)) begin
        tick();
        if (i == 0 && first_delay > 0) chk({tag, "_prime_en"}, ser_en, 0);
      end
      in_valid = 1'b1;
      in_word = words_q[i];
      if (poke && i == 0) begin
        start = 1'b1;
        num_words = 10'd7;
      end
      guard = 0;
      do begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard++;
      end while (!rdy && guard < 200);
      in_valid = 1'b0;
      if (guard >= 200) chk({tag, "_hs_timeout"}, guard, 0);
    end
    guard = 0;
    while (!done && guard < 20000) begin
      tick();
      guard++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_en_at_done"}, ser_en, 0);
    tick();
    tick();
    mon_on = 0;
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_ready_idle"}, in_ready, 0);
    chk({tag, "_underrun"}, underrun, (offer < n_eff));
    chk({tag, "_handshakes"}, hs_count, offer);
    chk({tag, "_en_cycles"}, en_cycles, 13 * offer);
    chk({tag, "_en_windows"}, en_rises, (offer > 0));
    chk({tag, "_done_pulses"}, done_count, 1);
    bad = (obs_bits.size() != exp_bits.size()) ? 1 : 0;
    for (int i = 0; i < exp_bits.size() && i < obs_bits.size(); i++)
      if (obs_bits[i] != exp_bits[i]) bad++;
    chk({tag, "_bits"}, bad, 0);
  endtask

  initial begin
    int nw, guard;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ser_en", ser_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);

    words_q = {13'h1A5};
    run_load("single", 1, 1, 0, 0, 0);

    words_q = {13'h0001, 13'h1FFF, 13'h0AAA};
    run_load("b2b", 3, 3, 0, 0, 1);

    words_q = {13'(($urandom))};
    run_load("underrun", 2, 1, 0, 0, 0);

    words_q = {};
    run_load("zero", 0, 0, 0, 0, 0);

    words_q = {13'(($urandom))};
    run_load("late", 1, 1, 50, 0, 0);

    for (int r = 0; r < 4; r++) begin
      nw = $urandom_range(8, 1);
      words_q = {};
      for (int i = 0; i < nw; i++) words_q.push_back(13'($urandom));
      run_load($sformatf("rand%0d", r), nw, nw, $urandom_range(5, 0), 8, 0);
    end

    words_q = {};
    for (int i = 0; i < 1000; i++) words_q.push_back(13'($urandom));
    run_load("clamp", 1023, 1000, 0, 0, 0);

    start = 1'b1;
    num_words = 10'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_word = 13'($urandom);
    guard = 0;
    while (!ser_en && guard < 50) begin
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk("midrst_shift", ser_en, 1);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("midrst_ser_en", ser_en, 0);
    chk("midrst_ser_data", ser_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_underrun", underrun, 0);

    words_q = {13'(($urandom))};
    run_load("after_rst", 1, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
